dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Pipeline-side initiator for the byte-addressed, big-endian data memory. It sits in the MEM stage between the pipeline and the memory port. It converts load/store requests of byte, halfword and word size into full-word memory transactions, waiting a fixed read latency for the memory's buffered read path. It performs byte-lane selection and sign/zero extension on loads, and read-modify-write on sub-word stores.

## Interface
Parameters:
- RD_LAT, 2, cycles `mem_memread`/address are held before `mem_data` is sampled; legal range 1..15

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when `req_valid && req_ready`
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified for sub-word
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, valid with `resp_valid`; 0 for stores
- resp_fault  out  1  misaligned access, valid with `resp_valid`
- mem_address  out  32  word-aligned address to memory
- mem_writedata  out  32  full word to memory
- mem_writeenable  out  1  memory write strobe
- mem_memread  out  1  memory read qualifier
- mem_data  in  32  memory read data

## Operation
- Byte order is big-endian: offset 0 maps to bits 31:24 and offset 3 to bits 7:0. Halfword offset 0 maps to 31:16 and offset 2 to 15:0.
- Accept: latch write, size, unsigned, addr and wdata. `mem_address = {req_addr[31:2],2'b00}`.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: `req_ready`=1. On accept:
  - word store -> WR
  - load or sub-word store -> RD, read counter loaded with RD_LAT-1
  - fault (see Configuration) -> RESP, no memory access
- RD: `mem_memread`=1; the counter decrements each cycle. When the counter is 0, capture `mem_data` into the read buffer.
  - If load: extract lane, extend to 32 bits -> RESP.
  - If sub-word store: merge right-justified wdata into the addressed lane(s) of the captured word -> WR.
- WR: `mem_writeenable`=1 for exactly one cycle, with `mem_writedata` = wdata (word) or merged word -> RESP.
- RESP: `resp_valid`=1 for one cycle -> IDLE. `req_ready` stays 0 in RESP.
- `mem_memread` and `mem_writeenable` are never high together. `mem_address`/`mem_writedata` are registered and stable from accept through WR.
- Reset (any state): immediate return to IDLE. All outputs go to 0, except `req_ready`=1. The transaction in flight is dropped with no response. A partial RMW never writes.

## Timing
Accept edge = cycle 0.
- Word store: WR in cycle 1, `resp_valid` in cycle 2.
- Load: RD in cycles 1..RD_LAT, `resp_valid` in cycle RD_LAT+1.
- Sub-word store: RD in cycles 1..RD_LAT, WR in cycle RD_LAT+1, `resp_valid` in cycle RD_LAT+2.
- Fault: `resp_valid` in cycle 1.
- Throughput: the next accept is possible in the cycle after RESP.
- No combinational path from `req_*` or `mem_data` to any output.

## Configuration
Macro: `DMAU_MISALIGN_TRAP_EN`.

Misaligned accesses are a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- Defined: a misaligned access issues no memory cycle. The response has `resp_fault`=1 and `resp_rdata`=0.
- Undefined: offending low address bits are forced to 0 (halfword clears bit 0, word clears bits 1:0) and the access proceeds normally. `resp_fault` is tied to 0.

## Test plan
- Word store then load, RD_LAT=2: store 0xDEADBEEF @0x10 -> one `mem_writeenable` pulse at 0x10, `resp_valid` at cycle 2. Load @0x10 -> `resp_rdata`=0xDEADBEEF at cycle 3.
- Byte loads on word 0x80FF7F01 @0x20:
  - signed @0x20 -> 0xFFFFFF80
  - unsigned @0x21 -> 0x000000FF
  - signed @0x22 -> 0x0000007F
- Halfword store 0xABCD @0x22 over 0x11223344 -> read then write of 0x1122ABCD. `resp_valid` at cycle RD_LAT+2.
- Misaligned word load @0x13:
  - With macro: `resp_fault`=1 at cycle 1, no `mem_memread`.
  - Without macro: reads 0x10, `resp_fault`=0.
- Reset asserted during RD of a byte store -> outputs drop to 0 immediately, no `mem_writeenable` pulse, no `resp_valid`. Memory word unchanged.
- Back-to-back: `req_valid` held high with three loads -> each accepted only in IDLE. `req_ready`=0 in RD and RESP. Three `resp_valid` pulses, correct data in order.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store initiator for big-endian word memory, sub-word stores by read-modify-write.
// Define DMAU_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing them aligned.
module dmem_access_unit #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_writeenable,
    output logic        mem_memread,
    input  logic [31:0] mem_data
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t state, state_nx;
    logic        accept, fault_in;
    logic [1:0]  off_in, off_q, size_q;
    logic        wr_q, uns_q;
    logic [15:0] wdata_q;
    logic [3:0]  cnt;
    logic [4:0]  sh_b, sh_h;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_val, merged;
    assign accept = req_valid && (state == IDLE);
`ifdef DMAU_MISALIGN_TRAP_EN
    assign fault_in = (req_size == 2'b01 && req_addr[0]) || (req_size[1] && req_addr[1:0] != 2'b00);
`else
    assign fault_in = 1'b0;
`endif
    // Lane offset with the low bits a halfword/word cannot use cleared
    assign off_in  = req_size[1] ? 2'b00 : req_size[0] ? {req_addr[1], 1'b0} : req_addr[1:0];
    assign sh_b    = {~off_q, 3'b000};
    assign sh_h    = {~off_q[1], 4'b0000};
    assign rd_byte = 8'(mem_data >> sh_b);
    assign rd_half = 16'(mem_data >> sh_h);
    assign ld_val  = size_q == 2'b00 ? {{24{~uns_q & rd_byte[7]}}, rd_byte}
                   : size_q == 2'b01 ? {{16{~uns_q & rd_half[15]}}, rd_half} : mem_data;
    assign merged  = size_q == 2'b00
                   ? (mem_data & ~(32'h0000_00FF << sh_b)) | ({24'b0, wdata_q[7:0]} << sh_b)
                   : (mem_data & ~(32'h0000_FFFF << sh_h)) | ({16'b0, wdata_q} << sh_h);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = fault_in ? RESP : (req_write && req_size[1]) ? WR : RD;
            RD:   if (cnt == 4'd0) state_nx = wr_q ? WR : RESP;
            WR:   state_nx = RESP;
            RESP: state_nx = IDLE;
        endcase
    end
    always_comb begin
        req_ready       = state == IDLE;
        mem_memread     = state == RD;
        mem_writeenable = state == WR;
        resp_valid      = state == RESP;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q          <= 1'b0;
            uns_q         <= 1'b0;
            size_q        <= 2'b00;
            off_q         <= 2'b00;
            wdata_q       <= 16'h0;
            cnt           <= 4'd0;
            mem_address   <= 32'h0;
            mem_writedata <= 32'h0;
            resp_rdata    <= 32'h0;
            resp_fault    <= 1'b0;
        end else if (accept) begin
            wr_q          <= req_write;
            uns_q         <= req_unsigned;
            size_q        <= req_size;
            off_q         <= off_in;
            wdata_q       <= req_wdata[15:0];
            cnt           <= 4'(RD_LAT - 1);
            mem_address   <= {req_addr[31:2], 2'b00};
            mem_writedata <= req_wdata;
            resp_rdata    <= 32'h0;
            resp_fault    <= fault_in;
        end else if (state == RD) begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else if (wr_q)   mem_writedata <= merged;
            else             resp_rdata <= ld_val;
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed load/store vectors checked against a byte-level memory model and literal expectations.
// Honours DMAU_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_access_unit;
    localparam int RD_LAT = 2;
    logic        clk = 0, reset_n = 0, req_valid = 0, req_write = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_fault, mem_writeenable, mem_memread;
    logic [31:0] resp_rdata, mem_address, mem_writedata, mem_data;
    logic [31:0] dm [64] = '{default: 32'h0};
    logic [7:0]  rb [256] = '{default: 8'h0};
    logic        pl_en = 0;
    logic [7:0]  pl_addr = 0;
    logic [31:0] pl_data = 0;
    int cyc = 0, rd_cnt = 0, reads_seen = 0, writes_seen = 0, total = 0, bad = 0;

    typedef struct {
        int due; logic [31:0] rdata; logic fault; logic hl; logic [31:0] lit;
        logic [31:0] waddr; int nw; int nr; int w0; int r0;
    } exp_t;
    exp_t q[$];
    exp_t e;

    dmem_access_unit #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_writeenable(mem_writeenable),
        .mem_memread(mem_memread), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory data only becomes valid once memread has been held RD_LAT cycles
    assign mem_data = (mem_memread && rd_cnt == RD_LAT - 1) ? dm[mem_address[7:2]] : 32'hDEAD_0BAD;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) dm[pl_addr[7:2]] <= pl_data;
        else if (mem_writeenable) dm[mem_address[7:2]] <= mem_writedata;
        if (mem_writeenable) writes_seen <= writes_seen + 1;
        if (mem_memread) reads_seen <= reads_seen + 1;
        rd_cnt <= mem_memread ? rd_cnt + 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (reset_n) begin
        chk("rd_wr_overlap", {31'b0, mem_memread & mem_writeenable}, 32'h0);
        chk("ready_while_busy", {31'b0, req_ready & (mem_memread | mem_writeenable | resp_valid)}, 32'h0);
        if ((mem_memread || mem_writeenable) && q.size() > 0) chk("mem_address", mem_address, q[0].waddr);
        if (resp_valid) begin
            if (q.size() == 0) chk("unexpected_resp", {31'b0, resp_valid}, 32'h0);
            else begin
                e = q.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.due));
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
                chk("write_pulses", 32'(writes_seen - e.w0), 32'(e.nw));
                chk("read_cycles", 32'(reads_seen - e.r0), 32'(e.nr));
                if (e.hl) chk("rdata_literal", resp_rdata, e.lit);
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        pl_en = 1; pl_addr = a; pl_data = w;
        {rb[{a[7:2], 2'd0}], rb[{a[7:2], 2'd1}], rb[{a[7:2], 2'd2}], rb[{a[7:2], 2'd3}]} = w;
        @(negedge clk);
        pl_en = 0;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] d, input logic hl, input logic [31:0] lit, input logic commit);
        exp_t x;
        logic mis, flt;
        logic [7:0] ea;
        logic [15:0] hv;
        logic [31:0] v;
        int n = 0;
        req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) begin total++; bad++; $display("FAIL accept_timeout: got ready=0 want 1"); end
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`ifdef DMAU_MISALIGN_TRAP_EN
        flt = mis;
`else
        flt = 1'b0;
`endif
        ea = sz[1] ? {a[7:2], 2'b00} : sz == 2'b01 ? {a[7:1], 1'b0} : a[7:0];
        hv = {rb[ea], rb[ea + 8'd1]};
        v = sz[1] ? {rb[ea], rb[ea + 8'd1], rb[ea + 8'd2], rb[ea + 8'd3]}
          : sz == 2'b01 ? (u ? {16'h0, hv} : {{16{hv[15]}}, hv})
          : (u ? {24'h0, rb[ea]} : {{24{rb[ea][7]}}, rb[ea]});
        x.due   = cyc + (flt ? 1 : (w && sz[1]) ? 2 : w ? RD_LAT + 2 : RD_LAT + 1);
        x.rdata = (flt || w) ? 32'h0 : v;
        x.fault = flt;
        x.hl    = hl;
        x.lit   = lit;
        x.waddr = {a[31:2], 2'b00};
        x.nw    = (w && !flt) ? 1 : 0;
        x.nr    = (flt || (w && sz[1])) ? 0 : RD_LAT;
        x.w0    = writes_seen;
        x.r0    = reads_seen;
        @(posedge clk);
        if (commit) begin
            q.push_back(x);
            if (w && !flt) begin
                if (sz[1]) {rb[ea], rb[ea + 8'd1], rb[ea + 8'd2], rb[ea + 8'd3]} = d;
                else if (sz == 2'b01) {rb[ea], rb[ea + 8'd1]} = d[15:0];
                else rb[ea] = d[7:0];
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 0;
        while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
        chk("drain_pending", 32'(q.size()), 32'h0);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
        chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'h0);
        chk({tag, "_memread"}, {31'b0, mem_memread}, 32'h0);
        chk({tag, "_writeenable"}, {31'b0, mem_writeenable}, 32'h0);
        chk({tag, "_mem_address"}, mem_address, 32'h0);
        chk({tag, "_mem_writedata"}, mem_writedata, 32'h0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_resp_fault"}, {31'b0, resp_fault}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int w0, mm;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1;
        @(negedge clk);
        // word store then load
        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 1); drain();
        issue(0, 2'b10, 0, 32'h10, 0, 1, 32'hDEADBEEF, 1); drain();
        // byte loads with sign/zero extension
        preload(8'h20, 32'h80FF7F01);
        issue(0, 2'b00, 0, 32'h20, 0, 1, 32'hFFFFFF80, 1); drain();
        issue(0, 2'b00, 1, 32'h21, 0, 1, 32'h000000FF, 1); drain();
        issue(0, 2'b00, 0, 32'h22, 0, 1, 32'h0000007F, 1); drain();
        issue(0, 2'b00, 0, 32'h23, 0, 1, 32'h00000001, 1); drain();
        // halfword RMW store
        preload(8'h20, 32'h11223344);
        issue(1, 2'b01, 0, 32'h22, 32'h0000ABCD, 0, 0, 1); drain();
        issue(0, 2'b10, 0, 32'h20, 0, 1, 32'h1122ABCD, 1); drain();
        // halfword loads
        preload(8'h40, 32'h8001FFFE);
        issue(0, 2'b01, 0, 32'h42, 0, 1, 32'hFFFFFFFE, 1); drain();
        issue(0, 2'b01, 1, 32'h40, 0, 1, 32'h00008001, 1); drain();
        issue(0, 2'b01, 0, 32'h40, 0, 1, 32'hFFFF8001, 1); drain();
        // byte RMW store
        preload(8'h30, 32'h01020304);
        issue(1, 2'b00, 0, 32'h31, 32'hFFFFFF5A, 0, 0, 1); drain();
        issue(0, 2'b10, 0, 32'h30, 0, 1, 32'h015A0304, 1); drain();
        // misaligned accesses
`ifdef DMAU_MISALIGN_TRAP_EN
        issue(0, 2'b10, 0, 32'h13, 0, 1, 32'h0, 1); drain();
        issue(1, 2'b01, 0, 32'h31, 32'h00007777, 0, 0, 1); drain();
        issue(0, 2'b10, 0, 32'h30, 0, 1, 32'h015A0304, 1); drain();
`else
        issue(0, 2'b10, 0, 32'h13, 0, 1, 32'hDEADBEEF, 1); drain();
        issue(1, 2'b01, 0, 32'h31, 32'h00007777, 0, 0, 1); drain();
        issue(0, 2'b10, 0, 32'h30, 0, 1, 32'h77770304, 1); drain();
`endif
        // size 11 behaves as word
        issue(0, 2'b11, 0, 32'h10, 0, 1, 32'hDEADBEEF, 1); drain();
        // reset during RD of a byte store
        preload(8'h50, 32'hCAFEF00D);
        w0 = writes_seen;
        issue(1, 2'b00, 0, 32'h51, 32'h000000EE, 0, 0, 0);
        chk("in_rd_before_reset", {31'b0, mem_memread}, 32'h1);
        reset_n = 0;
        #1;
        chk_reset_outputs("midreset");
        req_valid = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (4) @(negedge clk);
        chk("no_write_after_reset", 32'(writes_seen - w0), 32'h0);
        issue(0, 2'b10, 0, 32'h50, 0, 1, 32'hCAFEF00D, 1); drain();
        // back-to-back with req_valid held
        issue(0, 2'b01, 0, 32'h20, 0, 1, 32'h00001122, 1);
        issue(0, 2'b00, 1, 32'h23, 0, 1, 32'h000000CD, 1);
        issue(0, 2'b10, 0, 32'h10, 0, 1, 32'hDEADBEEF, 1);
        drain();
        mm = 0;
        for (int i = 0; i < 64; i++)
            if (dm[i] !== {rb[4 * i], rb[4 * i + 1], rb[4 * i + 2], rb[4 * i + 3]}) mm++;
        chk("mem_final_mismatch_words", 32'(mm), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
